// File: rtl/spike_sched_pkg.sv
// Shared types for the spike event scheduler: event payload, FSM state and
// counter width. Event fields are sized for the widest supported build; the
// scheduler zero-extends its TIME_WIDTH/ROW_WIDTH values into them.
package spike_sched_pkg;

    localparam int unsigned CNT_W          = 16;
    localparam int unsigned EV_TIME_W_MAX  = 32;
    localparam int unsigned EV_ROW_W_MAX   = 8;

    typedef struct packed {
        logic [EV_TIME_W_MAX-1:0] ts;
        logic [EV_ROW_W_MAX-1:0]  row;
    } spike_event_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // Saturating increment for the diagnostic counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spike_event_scheduler_if.sv
// Timestamped event stream (valid/ready) into the spike event scheduler.
interface spike_event_scheduler_if #(
    parameter int unsigned TIME_WIDTH = 16,
    parameter int unsigned ROW_WIDTH  = 1
);
    logic                  ev_valid;
    logic                  ev_ready;
    logic [TIME_WIDTH-1:0] ev_time;
    logic [ROW_WIDTH-1:0]  ev_row;

    modport master (output ev_valid, output ev_time, output ev_row, input ev_ready);
    modport slave  (input ev_valid, input ev_time, input ev_row, output ev_ready);
endinterface

// File: rtl/spike_event_fifo.sv
// Synchronous FIFO of spike events with a registered head entry and level.
// The head register is valid whenever the level is non-zero; a write into an
// empty FIFO becomes the head one cycle later.
module spike_event_fifo
    import spike_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  spike_event_t           wr_data_i,
    input  logic                   rd_en_i,
    output spike_event_t           head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    spike_event_t   mem_q [DEPTH];
    spike_event_t   head_q, head_d;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [LW-1:0]  level_q, level_d;
    logic           wr_fire, rd_fire;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign wr_fire    = wr_en_i && !full_o;
    assign rd_fire    = rd_en_i && !empty_o;
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign head_o     = head_q;
    assign level_o    = level_q;

    // Next level and next head: refill from storage on pop, or capture the
    // incoming entry when it becomes the only one.
    always_comb begin
        level_d = level_q;
        head_d  = head_q;
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (rd_fire) begin
            if (level_q > LW'(1)) begin
                head_d = mem_q[rd_ptr_nxt];
            end else if (wr_fire) begin
                head_d = wr_data_i;
            end
        end else if (empty_o && wr_fire) begin
            head_d = wr_data_i;
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, level and head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_nxt;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/spike_event_scheduler.sv
// Spike event scheduler: buffers timestamped (time, row) events and replays
// each as a one-cycle pulse on spike_out[row] when the run-time counter
// reaches its timestamp.
// Build option: SPIKE_SCHED_LATE_DROP_EN -- when defined, events whose time
// has already passed are discarded; otherwise they are emitted immediately.
// Both cases increment late_count.
module spike_event_scheduler
    import spike_sched_pkg::*;
#(
    parameter int unsigned NUM_SYNAPSE_ROWS = 2,
    parameter int unsigned TIME_WIDTH       = 16,
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned ROW_WIDTH        = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    spike_event_scheduler_if.slave        ev,
    output logic [NUM_SYNAPSE_ROWS-1:0]   spike_out,
    output logic [TIME_WIDTH-1:0]         now,
    output logic                          running,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic [CNT_W-1:0]              late_count,
    output logic [CNT_W-1:0]              bad_row_count
);

    sched_state_e                state_q;
    logic [TIME_WIDTH-1:0]       now_q;
    logic [NUM_SYNAPSE_ROWS-1:0] spike_q;
    logic [CNT_W-1:0]            late_q, bad_q;

    spike_event_t                wr_ev, head;
    logic                        fifo_empty, fifo_full;
    logic [TIME_WIDTH-1:0]       delta_c;
    logic                        due_c, late_c, row_ok_c, eval_c, pop_c, fire_c;
    logic [NUM_SYNAPSE_ROWS-1:0] onehot_c;

    assign wr_ev = '{ts:  EV_TIME_W_MAX'(ev.ev_time),
                     row: EV_ROW_W_MAX'(ROW_WIDTH'(ev.ev_row))};

    assign ev.ev_ready = !fifo_full;

    spike_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (ev.ev_valid),
        .wr_data_i (wr_ev),
        .rd_en_i   (pop_c),
        .head_o    (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .level_o   (fifo_level)
    );

    // Head match: modular distance to the head timestamp; MSB set means past.
    assign delta_c  = TIME_WIDTH'(head.ts - EV_TIME_W_MAX'(now_q));
    assign due_c    = (delta_c == '0);
    assign late_c   = delta_c[TIME_WIDTH-1];
    assign row_ok_c = (head.row < EV_ROW_W_MAX'(NUM_SYNAPSE_ROWS));
    assign eval_c   = (state_q == ST_RUN) && !stop && !fifo_empty;
    assign pop_c    = eval_c && (due_c || late_c);
    assign onehot_c = NUM_SYNAPSE_ROWS'(1) << head.row;

`ifdef SPIKE_SCHED_LATE_DROP_EN
    // Late events are consumed silently.
    assign fire_c = pop_c && row_ok_c && due_c;
`else
    // Late events are replayed as soon as they reach the head.
    assign fire_c = pop_c && row_ok_c;
`endif

    // Run/idle FSM, time counter, spike pulse register and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            now_q   <= '0;
            spike_q <= '0;
            late_q  <= '0;
            bad_q   <= '0;
        end else begin
            spike_q <= fire_c ? onehot_c : '0;
            if (pop_c && late_c)    late_q <= sat_inc(late_q);
            if (pop_c && !row_ok_c) bad_q  <= sat_inc(bad_q);
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q <= ST_RUN;
                        now_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        now_q <= '0;
                    end else begin
                        now_q <= now_q + TIME_WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spike_out     = spike_q;
    assign now           = now_q;
    assign running       = (state_q == ST_RUN);
    assign late_count    = late_q;
    assign bad_row_count = bad_q;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Scoreboard bench for spike_event_scheduler: two instances (16-bit and 4-bit
// time), a cycle-stepped reference model pushing expected pulses into queues,
// and a negedge monitor that pops and compares.
`timescale 1ns/1ps
module tb_spike_event_scheduler;
    import spike_sched_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned NROWS = 2;
    localparam int unsigned RW    = 2;
    localparam int unsigned TW0   = 16;
    localparam int unsigned TW1   = 4;
`ifdef SPIKE_SCHED_LATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [1:0]           start_b, stop_b, ev_valid_b;
    logic [1:0][15:0]     ev_time_b;
    logic [1:0][RW-1:0]   ev_row_b;

    spike_event_scheduler_if #(.TIME_WIDTH(TW0), .ROW_WIDTH(RW)) if0 ();
    spike_event_scheduler_if #(.TIME_WIDTH(TW1), .ROW_WIDTH(RW)) if1 ();

    assign if0.ev_valid = ev_valid_b[0];
    assign if0.ev_time  = ev_time_b[0];
    assign if0.ev_row   = ev_row_b[0];
    assign if1.ev_valid = ev_valid_b[1];
    assign if1.ev_time  = ev_time_b[1][TW1-1:0];
    assign if1.ev_row   = ev_row_b[1];

    logic [NROWS-1:0] spike0, spike1;
    logic [TW0-1:0]   now0;
    logic [TW1-1:0]   now1;
    logic             run0, run1;
    logic [3:0]       lvl0, lvl1;
    logic [15:0]      late0, late1, bad0, bad1;

    spike_event_scheduler #(.NUM_SYNAPSE_ROWS(NROWS), .TIME_WIDTH(TW0), .DEPTH(DEPTH), .ROW_WIDTH(RW)) dut0 (
        .clk(clk), .reset(reset), .start(start_b[0]), .stop(stop_b[0]), .ev(if0),
        .spike_out(spike0), .now(now0), .running(run0), .fifo_level(lvl0),
        .late_count(late0), .bad_row_count(bad0));

    spike_event_scheduler #(.NUM_SYNAPSE_ROWS(NROWS), .TIME_WIDTH(TW1), .DEPTH(DEPTH), .ROW_WIDTH(RW)) dut1 (
        .clk(clk), .reset(reset), .start(start_b[1]), .stop(stop_b[1]), .ev(if1),
        .spike_out(spike1), .now(now1), .running(run1), .fifo_level(lvl1),
        .late_count(late1), .bad_row_count(bad1));

    logic [1:0][15:0] a_now, a_late, a_bad;
    logic [1:0][3:0]  a_lvl;
    logic [1:0][1:0]  a_spk;
    logic [1:0]       a_run, a_rdy;
    assign a_now[0] = now0;   assign a_now[1] = 16'(now1);
    assign a_late[0] = late0; assign a_late[1] = late1;
    assign a_bad[0] = bad0;   assign a_bad[1] = bad1;
    assign a_lvl[0] = lvl0;   assign a_lvl[1] = lvl1;
    assign a_spk[0] = spike0; assign a_spk[1] = spike1;
    assign a_run[0] = run0;   assign a_run[1] = run1;
    assign a_rdy[0] = if0.ev_ready; assign a_rdy[1] = if1.ev_ready;

    // Reference model state
    int unsigned m_now [2];
    bit          m_run [2];
    int unsigned m_late[2];
    int unsigned m_bad [2];
    int unsigned q_t   [2][DEPTH];
    int unsigned q_r   [2][DEPTH];
    int unsigned q_n   [2];
    bit          m_acc [2];
    int          cyc = 0;
    bit          armed = 1'b0;

    typedef struct {
        int          cyc;
        int unsigned nowv;
        logic [1:0]  vec;
    } exp_t;
    exp_t exq0[$];
    exp_t exq1[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exv);
        n_cmp++;
        if (act !== exv) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d expected %0d", nm, d, cyc, act, exv);
        end
    endtask

    task automatic timeout_fail(input string nm, input int d);
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d cyc=%0d: wait bound expired", nm, d, cyc);
    endtask

    // Reference model: one step per clock edge from the scheduling rules.
    always @(posedge clk) begin
        int unsigned mask, msb, delta, pre_n, r0;
        bit          pop, emit;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            mask     = (d == 0) ? 32'hFFFF : 32'hF;
            msb      = (d == 0) ? 15 : 3;
            m_acc[d] = 1'b0;
            if (reset) begin
                m_now[d] = 0; m_run[d] = 1'b0; q_n[d] = 0;
                m_late[d] = 0; m_bad[d] = 0;
            end else begin
                pre_n = q_n[d];
                pop   = 1'b0;
                emit  = 1'b0;
                r0    = q_r[d][0];
                if (m_run[d] && !stop_b[d] && pre_n > 0) begin
                    delta = (q_t[d][0] - m_now[d]) & mask;
                    if (delta == 0) begin
                        pop  = 1'b1;
                        emit = (r0 < NROWS);
                    end else if (((delta >> msb) & 1) == 1) begin
                        pop  = 1'b1;
                        emit = (r0 < NROWS) && !DROP;
                        if (m_late[d] < 65535) m_late[d]++;
                    end
                end
                if (pop && r0 >= NROWS && m_bad[d] < 65535) m_bad[d]++;
                if (pop) begin
                    for (int i = 0; i + 1 < DEPTH; i++) begin
                        q_t[d][i] = q_t[d][i+1];
                        q_r[d][i] = q_r[d][i+1];
                    end
                    q_n[d]--;
                end
                if (ev_valid_b[d] && pre_n < DEPTH) begin
                    q_t[d][q_n[d]] = ev_time_b[d] & mask;
                    q_r[d][q_n[d]] = ev_row_b[d];
                    q_n[d]++;
                    m_acc[d] = 1'b1;
                end
                if (stop_b[d]) m_run[d] = 1'b0;
                else if (start_b[d]) begin m_run[d] = 1'b1; m_now[d] = 0; end
                else if (m_run[d]) m_now[d] = (m_now[d] + 1) & mask;
                if (emit) begin
                    e.cyc  = cyc + 1;
                    e.nowv = m_now[d];
                    e.vec  = 2'(1 << r0);
                    if (d == 0) exq0.push_back(e); else exq1.push_back(e);
                end
            end
        end
        cyc++;
        armed = 1'b1;
    end

    // Monitor: compare DUT outputs with model state and expected pulses.
    always @(negedge clk) begin
        exp_t e;
        bit   has;
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk("ev_ready", d, 32'(a_rdy[d]), 32'(q_n[d] < DEPTH));
                chk("now", d, 32'(a_now[d]), m_now[d]);
                chk("running", d, 32'(a_run[d]), 32'(m_run[d]));
                chk("fifo_level", d, 32'(a_lvl[d]), q_n[d]);
                chk("late_count", d, 32'(a_late[d]), m_late[d]);
                chk("bad_row_count", d, 32'(a_bad[d]), m_bad[d]);
                has = 1'b0;
                if (d == 0) begin
                    if (exq0.size() > 0 && exq0[0].cyc == cyc) begin e = exq0.pop_front(); has = 1'b1; end
                end else begin
                    if (exq1.size() > 0 && exq1[0].cyc == cyc) begin e = exq1.pop_front(); has = 1'b1; end
                end
                if (has) begin
                    chk("spike_vec", d, 32'(a_spk[d]), 32'(e.vec));
                    chk("spike_now", d, 32'(a_now[d]), e.nowv);
                end else begin
                    chk("spike_idle", d, 32'(a_spk[d]), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; start_b = '0; stop_b = '0; ev_valid_b = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start_b[d] = 1'b1; tick(); start_b[d] = 1'b0;
    endtask

    task automatic push_ev(input int d, input int unsigned t, input int unsigned r);
        bit ok;
        ok = 1'b0;
        ev_valid_b[d] = 1'b1; ev_time_b[d] = 16'(t); ev_row_b[d] = RW'(r);
        for (int i = 0; i < 500; i++) begin
            tick();
            if (m_acc[d]) begin ok = 1'b1; break; end
        end
        ev_valid_b[d] = 1'b0;
        if (!ok) timeout_fail("push_accept", d);
    endtask

    task automatic wait_now(input int d, input int unsigned v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_now[d] == v) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) timeout_fail("wait_now", d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          d;
        int unsigned t_next;
        reset = 1'b1; start_b = '0; stop_b = '0; ev_valid_b = '0;
        ev_time_b = '0; ev_row_b = '0;
        tick();
        do_reset();

        // Basic replay of four events
        push_ev(0, 50, 0); push_ev(0, 60, 0); push_ev(0, 100, 1); push_ev(0, 150, 1);
        pulse_start(0);
        ticks(170);
        chk("t1_late", 0, 32'(late0), 32'd0);
        chk("t1_bad", 0, 32'(bad0), 32'd0);

        // Equal timestamps: second one is late
        do_reset();
        push_ev(0, 20, 0); push_ev(0, 20, 1);
        pulse_start(0);
        ticks(40);
        chk("t2_late", 0, 32'(late0), 32'd1);

        // Fill FIFO in IDLE; extra event waits for a pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ev(0, 10 * (i + 1), i % 2);
        ev_valid_b[0] = 1'b1; ev_time_b[0] = 16'd90; ev_row_b[0] = 2'd1;
        ticks(4);
        chk("t3_level_full", 0, 32'(lvl0), DEPTH);
        chk("t3_ready_low", 0, 32'(if0.ev_ready), 32'd0);
        start_b[0] = 1'b1; tick(); start_b[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_acc[0]) begin ok = 1'b1; break; end
            tick();
        end
        ev_valid_b[0] = 1'b0;
        if (!ok) timeout_fail("t3_extra_accept", 0);
        ticks(100);

        // 4-bit time: event at 3 written at now=14 fires after wrap
        do_reset();
        pulse_start(1);
        wait_now(1, 14);
        ev_valid_b[1] = 1'b1; ev_time_b[1] = 16'd3; ev_row_b[1] = 2'd1;
        tick();
        ev_valid_b[1] = 1'b0;
        ticks(12);
        chk("t4_late", 1, 32'(late1), 32'd0);

        // Bad row
        do_reset();
        push_ev(0, 10, 3);
        pulse_start(0);
        ticks(20);
        chk("t5_bad", 0, 32'(bad0), 32'd1);

        // Reset mid-run flushes pending events
        do_reset();
        push_ev(0, 50, 0); push_ev(0, 60, 1); push_ev(0, 100, 0);
        pulse_start(0);
        wait_now(0, 55);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_spike", 0, 32'(spike0), 32'd0);
        chk("t6_now", 0, 32'(now0), 32'd0);
        chk("t6_level", 0, 32'(lvl0), 32'd0);
        chk("t6_ready", 0, 32'(if0.ev_ready), 32'd1);
        pulse_start(0);
        ticks(150);

        // Randomized traffic with occasional start/stop
        for (int round = 0; round < 6; round++) begin
            d = (round % 3 == 2) ? 1 : 0;
            do_reset();
            t_next = $urandom_range(0, 10);
            start_b[d] = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if (!ev_valid_b[d] || m_acc[d]) begin
                    ev_time_b[d] = 16'(t_next);
                    ev_row_b[d]  = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(2, 3)) : RW'($urandom_range(0, 1));
                    t_next += $urandom_range(0, 6);
                end
                ev_valid_b[d] = ($urandom_range(0, 99) < 40);
                if (c > 0) begin
                    start_b[d] = ($urandom_range(0, 199) == 0);
                    stop_b[d]  = ($urandom_range(0, 149) == 0);
                end
                tick();
            end
            ev_valid_b[d] = 1'b0; start_b[d] = 1'b0; stop_b[d] = 1'b0;
            ticks(5);
        end

        tick();
        chk("pending_exp0", 0, 32'(exq0.size()), 32'd0);
        chk("pending_exp1", 1, 32'(exq1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
